mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction cache and the data cache of one core.
- Registered grant FSM: picks one requester, drives RAM strobes/address/data from it, and returns per-requester wait.
- Data side has priority. A starvation counter forces an instruction grant after STARVE_LIMIT consecutive data completions while an instruction request is pending.
- Sits between the cache pair (icache, dcache) and the RAM model/controller.

Parameters:
- STARVE_LIMIT, 4: consecutive data completions allowed while iREN is pending before the next grant is forced to the instruction side. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  0 = iload valid this cycle and the request completes
- iload  out  32  read data to icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  0 = dcache access completes this cycle
- dload  out  32  read data to dcache
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR

Behaviour:
- Clock and reset: single clock CLK. nRST is asynchronous, active-low. On reset: state=IDLE, starve_cnt=0.
- Reset output values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- Load paths: iload and dload are continuous passthroughs of ramload. Requesters qualify the data with their own wait.
- States are IDLE, DSERVE and ISERVE.
- IDLE:
  - No RAM strobes; iwait=dwait=1.
  - Next state DSERVE if (dREN|dWEN) and not (iREN && starve_cnt==STARVE_LIMIT).
  - Otherwise ISERVE if iREN.
  - Otherwise IDLE.
- DSERVE:
  - Drives ramaddr=daddr and ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0 (a write wins when dREN and dWEN are both high). Otherwise ramREN=dREN.
  - dwait=0 only in the cycle ramstate==ACCESS. That cycle is the completion, and the next state is IDLE.
  - iwait stays 1 throughout.
- ISERVE:
  - Drives ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - iwait=0 only in the cycle ramstate==ACCESS; next state IDLE.
  - dwait stays 1 throughout.
- ramstate FREE/BUSY: remain in the serve state, wait held at 1.
- ramstate ERROR: remain in the serve state and keep strobes asserted (retry); wait held at 1.
- Request withdrawn mid-serve (granted side's REN/WEN low): strobes drop combinationally in that cycle, no completion, next state IDLE, counter unchanged.
- Latency: minimum 2 cycles from request to completion (one arbitration cycle, then the ACCESS cycle). There is no back-to-back grant without an IDLE cycle between them.
- Starvation counter:
  - On a DSERVE completion with iREN=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On an ISERVE completion, or any cycle with iREN=0: starve_cnt=0.
- Simultaneous requests in IDLE with starve_cnt<STARVE_LIMIT: data side wins.
- The grant never changes while in a serve state, regardless of new requests from the other side.
- Outputs ramREN/ramWEN/ramaddr/ramstore are combinational from state and the granted requester's inputs. Waits are combinational from state and ramstate.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds outputs icount (out, 32) and dcount (out, 32).
  - Each is a free-running count of completed instruction/data accesses.
  - Both reset to 0, increment by 1 on the completion cycle, and wrap from 0xFFFFFFFF to 0.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset and idle: hold nRST=0 with iREN=dREN=1 → ramREN=0, ramWEN=0, iwait=dwait=1. Release, no requests → stays IDLE with no strobes.
- Single read: iREN=1, iaddr=0x40, ramstate BUSY for 3 cycles then ACCESS with ramload=0xDEADBEEF → ramaddr=0x40, ramREN=1 from cycle 2. iwait=0 and iload=0xDEADBEEF only in the ACCESS cycle.
- Contention: iREN and dWEN (daddr=0x80, dstore=0x1234) raised together → data served first: ramWEN=1, ramstore=0x1234. Instruction granted after an IDLE cycle.
- Starvation: iREN held; dREN re-requested continuously with immediate ACCESS, STARVE_LIMIT=4 → exactly 4 data completions, then ISERVE. The counter returns to 0 after the instruction completion.
- Withdrawal and error: dREN dropped while ramstate=BUSY → strobes drop, return to IDLE, no dwait=0 pulse. ramstate=ERROR for 2 cycles then ACCESS → strobes held, single completion.
- Stats (MEM_ARB_STATS_EN): 3 instruction and 2 data completions → icount=3, dcount=2. Preload to 0xFFFFFFFF plus one completion → wraps to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between the icache and the dcache. The data side has priority.
// Define MEM_ARB_STATS_EN to add the icount/dcount completion counters.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    // state  | meaning
    // IDLE   | no grant; arbitrate for the next cycle
    // DSERVE | dcache owns the RAM until ACCESS or withdrawal
    // ISERVE | icache owns the RAM until ACCESS or withdrawal
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DSERVE = 2'b01,
        ISERVE = 2'b10
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'b10;
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);

    state_t           state_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             d_req;
    logic             d_done;
    logic             i_done;
    logic             starved;

    assign iload   = ramload;
    assign dload   = ramload;
    assign d_req   = dREN | dWEN;
    assign starved = iREN && (starve_cnt_q == LIMIT);

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        d_done   = 1'b0;
        i_done   = 1'b0;
        case (state_q)
            DSERVE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                // A withdrawn request never completes, even if the RAM reports ACCESS.
                if (d_req && (ramstate == RAM_ACCESS)) begin
                    dwait  = 1'b0;
                    d_done = 1'b1;
                end
            end
            ISERVE: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && (ramstate == RAM_ACCESS)) begin
                    iwait  = 1'b0;
                    i_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_req && !starved)
                        state_q <= DSERVE;
                    else if (iREN)
                        state_q <= ISERVE;
                end
                DSERVE: if (!d_req || d_done) state_q <= IDLE;
                ISERVE: if (!iREN || i_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt_q <= '0;
        else if (!iREN || i_done)
            starve_cnt_q <= '0;
        else if (d_done && (starve_cnt_q != LIMIT))
            starve_cnt_q <= starve_cnt_q + 1'b1;
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount_q;
    logic [31:0] dcount_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q <= 32'h0;
            dcount_q <= 32'h0;
        end else begin
            if (i_done) icount_q <= icount_q + 32'h1;
            if (d_done) dcount_q <= dcount_q + 32'h1;
        end
    end

    assign icount = icount_q;
    assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-by-cycle vector table plus hand sequences
// for starvation and async reset. Stats counters are checked when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount, dcount;
`endif

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_STATS_EN
        , .icount(icount), .dcount(dcount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren, dren, dwen;
        logic [31:0] iaddr, daddr, dstore, ramload;
        logic [1:0]  rs;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iw, e_dw;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic ir, logic dr, logic dw, logic [31:0] ia, logic [31:0] da,
                                logic [31:0] ds, logic [31:0] rl, logic [1:0] rs,
                                logic er, logic ew, logic [31:0] ea, logic [31:0] es,
                                logic eiw, logic edw);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.ramload = rl; v.rs = rs;
        v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
        v.e_iw = eiw; v.e_dw = edw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
        iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore;
        ramload = v.ramload; ramstate = v.rs;
    endtask

    initial begin
        int exp_ic, exp_dc, dcomp, cyc;
        bit saw_i;

        // A: idle
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(0,0,0, 0,0,0, 0, FREE, 0,0,0,0, 1,1));
        // B: single instruction read, 3 BUSY then ACCESS
        vecs.push_back(mk(1,0,0, 32'h40,0,0, 0, FREE, 0,0,0,0, 1,1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1,0,0, 32'h40,0,0, 0, BUSY, 1,0,32'h40,0, 1,1));
        vecs.push_back(mk(1,0,0, 32'h40,0,0, 32'hDEADBEEF, ACC, 1,0,32'h40,0, 0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, FREE, 0,0,0,0, 1,1));
        // C: contention, data write first, instruction after an idle cycle
        vecs.push_back(mk(1,0,1, 32'h44,32'h80,32'h1234, 0, FREE, 0,0,0,0, 1,1));
        vecs.push_back(mk(1,0,1, 32'h44,32'h80,32'h1234, 0, ACC, 0,1,32'h80,32'h1234, 1,0));
        vecs.push_back(mk(1,0,0, 32'h44,32'h80,32'h1234, 0, FREE, 0,0,0,0, 1,1));
        vecs.push_back(mk(1,0,0, 32'h44,32'h80,32'h1234, 0, ACC, 1,0,32'h44,0, 0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, FREE, 0,0,0,0, 1,1));
        // D: starvation, 4 data completions then forced instruction grant, counter cleared
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(1,1,0, 32'h48,32'h90,32'h5555, 0, ACC, 0,0,0,0, 1,1));
            vecs.push_back(mk(1,1,0, 32'h48,32'h90,32'h5555, 0, ACC, 1,0,32'h90,32'h5555, 1,0));
        end
        vecs.push_back(mk(1,1,0, 32'h48,32'h90,32'h5555, 0, ACC, 0,0,0,0, 1,1));
        vecs.push_back(mk(1,1,0, 32'h48,32'h90,32'h5555, 0, ACC, 1,0,32'h48,0, 0,1));
        vecs.push_back(mk(1,1,0, 32'h48,32'h90,32'h5555, 0, ACC, 0,0,0,0, 1,1));
        vecs.push_back(mk(1,1,0, 32'h48,32'h90,32'h5555, 0, ACC, 1,0,32'h90,32'h5555, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, FREE, 0,0,0,0, 1,1));
        // E: withdrawal while BUSY, then ERROR retry
        vecs.push_back(mk(0,1,0, 0,32'hA0,32'h77, 0, BUSY, 0,0,0,0, 1,1));
        vecs.push_back(mk(0,1,0, 0,32'hA0,32'h77, 0, BUSY, 1,0,32'hA0,32'h77, 1,1));
        vecs.push_back(mk(0,0,0, 0,32'hA0,32'h77, 0, BUSY, 0,0,32'hA0,32'h77, 1,1));
        vecs.push_back(mk(0,0,0, 0,32'hA0,32'h77, 0, ACC, 0,0,0,0, 1,1));
        vecs.push_back(mk(0,1,0, 0,32'hB0,32'h88, 0, FREE, 0,0,0,0, 1,1));
        vecs.push_back(mk(0,1,0, 0,32'hB0,32'h88, 0, ERR, 1,0,32'hB0,32'h88, 1,1));
        vecs.push_back(mk(0,1,0, 0,32'hB0,32'h88, 0, ERR, 1,0,32'hB0,32'h88, 1,1));
        vecs.push_back(mk(0,1,0, 0,32'hB0,32'h88, 0, ACC, 1,0,32'hB0,32'h88, 1,0));
        vecs.push_back(mk(0,0,0, 0,32'hB0,32'h88, 0, ACC, 0,0,0,0, 1,1));
        // F: read and write together, write wins
        vecs.push_back(mk(0,1,1, 0,32'hC0,32'hCAFE, 0, FREE, 0,0,0,0, 1,1));
        vecs.push_back(mk(0,1,1, 0,32'hC0,32'hCAFE, 0, ACC, 0,1,32'hC0,32'hCAFE, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, FREE, 0,0,0,0, 1,1));

        // Reset with requests asserted
        nRST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h11; daddr = 32'h22; dstore = 32'h33; ramload = 32'h0; ramstate = ACC;
        #3;
        chk("rst_ren", 32'(ramREN), 32'd0);
        chk("rst_wen", 32'(ramWEN), 32'd0);
        chk("rst_addr", ramaddr, 32'h0);
        chk("rst_store", ramstore, 32'h0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
`ifdef MEM_ARB_STATS_EN
        chk("rst_icount", icount, 32'h0);
        chk("rst_dcount", dcount, 32'h0);
`endif
        step();
        step();
        nRST = 1'b1;

        exp_ic = 0;
        exp_dc = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] rl;
            v = vecs[i];
            rl = (v.ramload != 32'h0) ? v.ramload : (32'h5A000000 | 32'(i));
            v.ramload = rl;
            drive(v);
            #4;
            chk($sformatf("v%0d_ren", i), 32'(ramREN), 32'(v.e_ren));
            chk($sformatf("v%0d_wen", i), 32'(ramWEN), 32'(v.e_wen));
            chk($sformatf("v%0d_addr", i), ramaddr, v.e_addr);
            chk($sformatf("v%0d_store", i), ramstore, v.e_store);
            chk($sformatf("v%0d_iwait", i), 32'(iwait), 32'(v.e_iw));
            chk($sformatf("v%0d_dwait", i), 32'(dwait), 32'(v.e_dw));
            chk($sformatf("v%0d_iload", i), iload, rl);
            chk($sformatf("v%0d_dload", i), dload, rl);
            if (!v.e_iw) exp_ic++;
            if (!v.e_dw) exp_dc++;
            step();
        end

`ifdef MEM_ARB_STATS_EN
        chk("stats_icount", icount, 32'(exp_ic));
        chk("stats_dcount", dcount, 32'(exp_dc));
`endif

        // Starvation under a cycle budget: exactly 4 data completions before the icache is served
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h200; daddr = 32'h300; dstore = 32'h0; ramstate = ACC;
        dcomp = 0;
        saw_i = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            #4;
            if (!iwait) begin
                saw_i = 1'b1;
                break;
            end
            if (!dwait) dcomp++;
            step();
        end
        chk("starve_i_served", 32'(saw_i), 32'd1);
        chk("starve_dcomp", 32'(dcomp), 32'd4);
        step();
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        step();

        // Async reset in the middle of a data grant
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        step();
        #1;
        chk("mid_ren_before", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_ren_after", 32'(ramREN), 32'd0);
        chk("mid_addr_after", ramaddr, 32'h0);
        chk("mid_dwait_after", 32'(dwait), 32'd1);
`ifdef MEM_ARB_STATS_EN
        chk("mid_icount", icount, 32'h0);
`endif
        step();
        dREN = 1'b0;
        nRST = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
